// File: rtl/adc_pkg.sv
// Shared state encoding and default parameter values for the ADC sync controller.
package adc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_PPS = 3'd1,
      ST_SYNC     = 3'd2,
      ST_SETTLE   = 3'd3,
      ST_RUN      = 3'd4
   } adc_state_e;

   localparam int DEF_SYNC_PULSE_CYCLES = 4;
   localparam int DEF_SETTLE_FRAMES     = 2;
   localparam int DEF_SAMPLES_PER_SEC   = 4000;
   localparam int DEF_PPS_TIMEOUT       = 8_600_000;

endpackage

// File: rtl/pps_edge_detect.sv
// Two-flop synchronizer for the asynchronous GPS PPS input followed by a registered
// rising-edge detector; PPS_EDGE is a one-cycle pulse three MCLK edges after the input rises.
module pps_edge_detect (
   input  logic MCLK,
   input  logic nRST,
   input  logic PPS_IN,
   output logic PPS_EDGE
);

   logic [2:0] sync_q;
   logic       edge_q;

   always_ff @(posedge MCLK or negedge nRST) begin
      if (!nRST) begin
         sync_q <= 3'b000;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], PPS_IN};
         edge_q <= sync_q[1] & ~sync_q[2];
      end
   end

   assign PPS_EDGE = edge_q;

endmodule

// File: rtl/adc_sync_controller.sv
// Aligns ADC conversions to GPS PPS: issues an nSYNC pulse, discards settling frames,
// then indexes frames within each second and watches for frame slips and PPS loss.
module adc_sync_controller
   import adc_pkg::*;
#(
   parameter int SYNC_PULSE_CYCLES = DEF_SYNC_PULSE_CYCLES,
   parameter int SETTLE_FRAMES     = DEF_SETTLE_FRAMES,
   parameter int SAMPLES_PER_SEC   = DEF_SAMPLES_PER_SEC,
   parameter int PPS_TIMEOUT       = DEF_PPS_TIMEOUT
) (
   input  logic        MCLK,
   input  logic        nRST,
   input  logic        ENABLE,
   input  logic        PPS_IN,
   input  logic        DATA_READY_IN,
   output logic        nSYNC_OUT,
   output logic        SAMPLE_VALID,
   output logic [15:0] SAMPLE_INDEX,
   output logic [31:0] SECOND_COUNT,
   output logic        LOCKED,
   output logic        PPS_LOST,
   output logic        SLIP,
   output adc_state_e  state_dbg_o
);

   localparam logic [7:0]  PULSE_LAST  = 8'(SYNC_PULSE_CYCLES - 1);
   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_FRAMES - 1);
   localparam logic [15:0] SPS         = 16'(SAMPLES_PER_SEC);
   localparam logic [15:0] SPS_LAST    = 16'(SAMPLES_PER_SEC - 1);
   localparam logic [23:0] TIMEOUT     = 24'(PPS_TIMEOUT);

   logic        pps_edge;
   adc_state_e  state_q, state_d;
   logic [7:0]  pulse_cnt_q, pulse_cnt_d;
   logic [3:0]  settle_cnt_q, settle_cnt_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [31:0] sec_cnt_q, sec_cnt_d;
   logic [23:0] to_cnt_q, to_cnt_d;
   logic        first_pps_q, first_pps_d;
   logic        lost_q, lost_d;
   logic        slip_q, slip_d;
   logic        valid_q, valid_d;
   logic [15:0] index_q, index_d;
   logic [15:0] frame_inc;
   logic        run_entry;

   pps_edge_detect u_pps_edge (
      .MCLK     (MCLK),
      .nRST     (nRST),
      .PPS_IN   (PPS_IN),
      .PPS_EDGE (pps_edge)
   );

   assign frame_inc = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;

   always_comb begin
      state_d      = state_q;
      pulse_cnt_d  = pulse_cnt_q;
      settle_cnt_d = settle_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      sec_cnt_d    = sec_cnt_q;
      first_pps_d  = first_pps_q;
      slip_d       = slip_q;
      valid_d      = 1'b0;
      index_d      = index_q;
      to_cnt_d     = to_cnt_q;
      lost_d       = lost_q;
      run_entry    = 1'b0;

      // PPS watchdog runs in every active state; any PPS edge clears a pending loss.
      if (pps_edge) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TIMEOUT) begin
         to_cnt_d = to_cnt_q + 24'd1;
      end
      lost_d = pps_edge ? 1'b0 : (lost_q || (to_cnt_d == TIMEOUT));

      unique case (state_q)
         ST_IDLE: begin
            to_cnt_d = '0;
            lost_d   = 1'b0;
            if (ENABLE) state_d = ST_WAIT_PPS;
         end
         ST_WAIT_PPS: begin
            if (pps_edge) begin
               state_d     = ST_SYNC;
               pulse_cnt_d = '0;
            end
         end
         ST_SYNC: begin
            if (pulse_cnt_q == PULSE_LAST) begin
               if (SETTLE_FRAMES == 0) begin
                  run_entry = 1'b1;
               end else begin
                  state_d      = ST_SETTLE;
                  settle_cnt_d = '0;
               end
            end else begin
               pulse_cnt_d = pulse_cnt_q + 8'd1;
            end
         end
         ST_SETTLE: begin
            if (DATA_READY_IN) begin
               if (settle_cnt_q == SETTLE_LAST) run_entry = 1'b1;
               else settle_cnt_d = settle_cnt_q + 4'd1;
            end
         end
         ST_RUN: begin
            // SAMPLE_VALID is a one-cycle strobe with no backpressure; SAMPLE_INDEX holds until the next strobe.
            if (DATA_READY_IN) begin
               valid_d = 1'b1;
               index_d = pps_edge ? 16'd0 : frame_cnt_q;
            end
            if (pps_edge) begin
               if (lost_q) begin
                  state_d     = ST_SYNC;
                  pulse_cnt_d = '0;
               end else if (first_pps_q || (frame_cnt_q == SPS)) begin
                  // A strobe coinciding with the edge is frame 0 of the new second.
                  first_pps_d = 1'b0;
                  frame_cnt_d = DATA_READY_IN ? 16'd1 : 16'd0;
                  if (!first_pps_q) sec_cnt_d = sec_cnt_q + 32'd1;
               end else begin
                  slip_d      = 1'b1;
                  state_d     = ST_SYNC;
                  pulse_cnt_d = '0;
               end
            end else if (DATA_READY_IN) begin
               if (lost_q && (frame_cnt_q >= SPS_LAST)) begin
                  frame_cnt_d = '0;
                  sec_cnt_d   = sec_cnt_q + 32'd1;
               end else begin
                  frame_cnt_d = frame_inc;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (run_entry) begin
         state_d     = ST_RUN;
         frame_cnt_d = '0;
         sec_cnt_d   = '0;
         first_pps_d = 1'b1;
      end

      if (!ENABLE) begin
         state_d      = ST_IDLE;
         pulse_cnt_d  = '0;
         settle_cnt_d = '0;
         frame_cnt_d  = '0;
         sec_cnt_d    = '0;
         first_pps_d  = 1'b0;
         slip_d       = 1'b0;
         valid_d      = 1'b0;
         index_d      = '0;
         to_cnt_d     = '0;
         lost_d       = 1'b0;
      end
   end

   always_ff @(posedge MCLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= ST_IDLE;
         pulse_cnt_q  <= '0;
         settle_cnt_q <= '0;
         frame_cnt_q  <= '0;
         sec_cnt_q    <= '0;
         to_cnt_q     <= '0;
         first_pps_q  <= 1'b0;
         lost_q       <= 1'b0;
         slip_q       <= 1'b0;
         valid_q      <= 1'b0;
         index_q      <= '0;
      end else begin
         state_q      <= state_d;
         pulse_cnt_q  <= pulse_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         sec_cnt_q    <= sec_cnt_d;
         to_cnt_q     <= to_cnt_d;
         first_pps_q  <= first_pps_d;
         lost_q       <= lost_d;
         slip_q       <= slip_d;
         valid_q      <= valid_d;
         index_q      <= index_d;
      end
   end

   // Decoded from the state register so an asynchronous reset releases it at once.
   assign nSYNC_OUT    = (state_q != ST_SYNC);
   assign SAMPLE_VALID = valid_q;
   assign SAMPLE_INDEX = index_q;
   assign SECOND_COUNT = sec_cnt_q;
   assign LOCKED       = (state_q == ST_RUN) && !lost_q;
   assign PPS_LOST     = lost_q;
   assign SLIP         = slip_q;
   assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_adc_sync_controller.sv
// Directed bench: free-running PPS (every 512 cycles) and DATA_READY (every 64 cycles)
// generators, with scenario tasks checking outputs at hand-computed cycle numbers.
module tb_adc_sync_controller;
   import adc_pkg::*;

   logic        clk = 1'b0;
   logic        nrst;
   logic        enable;
   logic        pps_in = 1'b0;
   logic        data_ready = 1'b0;
   logic        nsync;
   logic        sample_valid;
   logic [15:0] sample_index;
   logic [31:0] second_count;
   logic        locked;
   logic        pps_lost;
   logic        slip;
   adc_state_e  state_dbg;

   int checks = 0;
   int failures = 0;
   int gcyc = 0;
   bit pps_en = 1'b0;
   bit dr_en = 1'b1;
   int dr_phase = 32;
   int drop_at = -1;
   int valid_cnt = 0;
   int low_cnt = 0;
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];

   adc_sync_controller #(
      .SYNC_PULSE_CYCLES (4),
      .SETTLE_FRAMES     (2),
      .SAMPLES_PER_SEC   (8),
      .PPS_TIMEOUT       (1200)
   ) dut (
      .MCLK          (clk),
      .nRST          (nrst),
      .ENABLE        (enable),
      .PPS_IN        (pps_in),
      .DATA_READY_IN (data_ready),
      .nSYNC_OUT     (nsync),
      .SAMPLE_VALID  (sample_valid),
      .SAMPLE_INDEX  (sample_index),
      .SECOND_COUNT  (second_count),
      .LOCKED        (locked),
      .PPS_LOST      (pps_lost),
      .SLIP          (slip),
      .state_dbg_o   (state_dbg)
   );

   // Clock and stimulus generators; gcyc equals the index of the last posedge.
   initial forever #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         gcyc = gcyc + 1;
         pps_in     = pps_en && ((gcyc % 512) < 8);
         data_ready = dr_en && ((gcyc % 64) == dr_phase) && (gcyc != drop_at);
      end
   end

   // Advance on negedges until cycle target, logging strobes and nSYNC low cycles.
   task automatic step_to(input int target);
      int guard;
      guard = 0;
      while (gcyc < target && guard < 20000) begin
         @(negedge clk);
         guard++;
         if (sample_valid === 1'b1) begin
            valid_cnt++;
            got_q.push_back(sample_index);
         end
         if (nsync === 1'b0) low_cnt++;
      end
      if (gcyc < target) begin
         failures++;
         $display("FAIL step_timeout got=%0d exp=%0d", gcyc, target);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      enable = 1'b0;
      step_to(5);
      checks++; if (nsync !== 1'b1) begin failures++; $display("FAIL reset_nsync got=%0b exp=1", nsync); end
      checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", sample_valid); end
      checks++; if (sample_index !== 16'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", sample_index); end
      checks++; if (second_count !== 32'd0) begin failures++; $display("FAIL reset_sec got=%0d exp=0", second_count); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
      checks++; if (pps_lost !== 1'b0) begin failures++; $display("FAIL reset_lost got=%0b exp=0", pps_lost); end
      checks++; if (slip !== 1'b0) begin failures++; $display("FAIL reset_slip got=%0b exp=0", slip); end
      checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
      nrst = 1'b1;
      step_to(10);
      checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL idle_hold got=%0d exp=%0d", state_dbg, ST_IDLE); end
      enable = 1'b1;
      pps_en = 1'b1;
      step_to(11);
      checks++; if (state_dbg !== ST_WAIT_PPS) begin failures++; $display("FAIL enter_wait got=%0d exp=%0d", state_dbg, ST_WAIT_PPS); end
   endtask

   task automatic test_lock();
      low_cnt = 0;
      step_to(515);
      checks++; if (nsync !== 1'b1) begin failures++; $display("FAIL lock_pre_nsync got=%0b exp=1", nsync); end
      step_to(516);
      checks++; if (nsync !== 1'b0) begin failures++; $display("FAIL lock_nsync_start got=%0b exp=0", nsync); end
      checks++; if (state_dbg !== ST_SYNC) begin failures++; $display("FAIL lock_sync_state got=%0d exp=%0d", state_dbg, ST_SYNC); end
      step_to(530);
      checks++; if (low_cnt != 4) begin failures++; $display("FAIL lock_pulse_width got=%0d exp=4", low_cnt); end
      checks++; if (state_dbg !== ST_SETTLE) begin failures++; $display("FAIL lock_settle_state got=%0d exp=%0d", state_dbg, ST_SETTLE); end
      valid_cnt = 0;
      step_to(609);
      checks++; if (valid_cnt != 0) begin failures++; $display("FAIL settle_no_valid got=%0d exp=0", valid_cnt); end
      checks++; if (state_dbg !== ST_RUN) begin failures++; $display("FAIL lock_run_state got=%0d exp=%0d", state_dbg, ST_RUN); end
      got_q.delete();
      step_to(1539);
      checks++; if (second_count !== 32'd0) begin failures++; $display("FAIL lock_sec_before got=%0d exp=0", second_count); end
      step_to(1545);
      checks++; if (second_count !== 32'd1) begin failures++; $display("FAIL lock_sec_after got=%0d exp=1", second_count); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_locked got=%0b exp=1", locked); end
      checks++; if (slip !== 1'b0) begin failures++; $display("FAIL lock_slip got=%0b exp=0", slip); end
      exp_q.delete();
      for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
      for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL lock_index_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL lock_index[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_slip();
      drop_at = 1696;
      step_to(2051);
      checks++; if (slip !== 1'b0) begin failures++; $display("FAIL slip_pre got=%0b exp=0", slip); end
      checks++; if (nsync !== 1'b1) begin failures++; $display("FAIL slip_pre_nsync got=%0b exp=1", nsync); end
      step_to(2052);
      checks++; if (slip !== 1'b1) begin failures++; $display("FAIL slip_set got=%0b exp=1", slip); end
      checks++; if (nsync !== 1'b0) begin failures++; $display("FAIL slip_nsync got=%0b exp=0", nsync); end
      checks++; if (state_dbg !== ST_SYNC) begin failures++; $display("FAIL slip_state got=%0d exp=%0d", state_dbg, ST_SYNC); end
      step_to(2570);
      checks++; if (state_dbg !== ST_RUN) begin failures++; $display("FAIL slip_relock got=%0d exp=%0d", state_dbg, ST_RUN); end
      checks++; if (slip !== 1'b1) begin failures++; $display("FAIL slip_sticky got=%0b exp=1", slip); end
      checks++; if (second_count !== 32'd0) begin failures++; $display("FAIL slip_sec_clear got=%0d exp=0", second_count); end
   endtask

   task automatic test_coincidence();
      step_to(2600);
      dr_phase = 3;
      got_q.delete();
      step_to(3075);
      checks++; if (got_q.size() != 7) begin failures++; $display("FAIL coin_pre_count got=%0d exp=7", got_q.size()); end
      else begin
         checks++; if (got_q[6] !== 16'd7) begin failures++; $display("FAIL coin_pre_last got=%0d exp=7", got_q[6]); end
      end
      step_to(3076);
      checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL coin_valid got=%0b exp=1", sample_valid); end
      checks++; if (sample_index !== 16'd0) begin failures++; $display("FAIL coin_index got=%0d exp=0", sample_index); end
      checks++; if (second_count !== 32'd1) begin failures++; $display("FAIL coin_sec got=%0d exp=1", second_count); end
      checks++; if (state_dbg !== ST_RUN) begin failures++; $display("FAIL coin_state got=%0d exp=%0d", state_dbg, ST_RUN); end
      step_to(3140);
      checks++; if (sample_index !== 16'd1) begin failures++; $display("FAIL coin_next_index got=%0d exp=1", sample_index); end
      step_to(3588);
      checks++; if (sample_index !== 16'd0) begin failures++; $display("FAIL coin2_index got=%0d exp=0", sample_index); end
      checks++; if (second_count !== 32'd2) begin failures++; $display("FAIL coin2_sec got=%0d exp=2", second_count); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL coin2_locked got=%0b exp=1", locked); end
   endtask

   task automatic test_pps_loss();
      step_to(3600);
      pps_en = 1'b0;
      step_to(4787);
      checks++; if (pps_lost !== 1'b0) begin failures++; $display("FAIL loss_early got=%0b exp=0", pps_lost); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL loss_early_locked got=%0b exp=1", locked); end
      step_to(4788);
      checks++; if (pps_lost !== 1'b1) begin failures++; $display("FAIL loss_set got=%0b exp=1", pps_lost); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_locked got=%0b exp=0", locked); end
      got_q.delete();
      step_to(5390);
      exp_q.delete();
      exp_q.push_back(16'd19);
      for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
      exp_q.push_back(16'd0);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL holdover_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL holdover_index[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
         end
      end
      checks++; if (second_count !== 32'd4) begin failures++; $display("FAIL holdover_sec got=%0d exp=4", second_count); end
      pps_en = 1'b1;
      step_to(5635);
      checks++; if (pps_lost !== 1'b1) begin failures++; $display("FAIL restore_pre got=%0b exp=1", pps_lost); end
      step_to(5636);
      checks++; if (pps_lost !== 1'b0) begin failures++; $display("FAIL restore_clear got=%0b exp=0", pps_lost); end
      checks++; if (state_dbg !== ST_SYNC) begin failures++; $display("FAIL restore_state got=%0d exp=%0d", state_dbg, ST_SYNC); end
      checks++; if (nsync !== 1'b0) begin failures++; $display("FAIL restore_nsync got=%0b exp=0", nsync); end
      step_to(5640);
      checks++; if (state_dbg !== ST_SETTLE) begin failures++; $display("FAIL restore_settle got=%0d exp=%0d", state_dbg, ST_SETTLE); end
   endtask

   task automatic test_abort();
      step_to(5700);
      checks++; if (state_dbg !== ST_SETTLE) begin failures++; $display("FAIL abort_pre got=%0d exp=%0d", state_dbg, ST_SETTLE); end
      enable = 1'b0;
      step_to(5701);
      checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL abort_idle got=%0d exp=%0d", state_dbg, ST_IDLE); end
      checks++; if (slip !== 1'b0) begin failures++; $display("FAIL abort_slip got=%0b exp=0", slip); end
      checks++; if (second_count !== 32'd0) begin failures++; $display("FAIL abort_sec got=%0d exp=0", second_count); end
      enable = 1'b1;
      step_to(5702);
      checks++; if (state_dbg !== ST_WAIT_PPS) begin failures++; $display("FAIL abort_rewait got=%0d exp=%0d", state_dbg, ST_WAIT_PPS); end
      step_to(6149);
      checks++; if (nsync !== 1'b0) begin failures++; $display("FAIL abort_pulse got=%0b exp=0", nsync); end
      #2;
      nrst = 1'b0;
      #1;
      checks++; if (nsync !== 1'b1) begin failures++; $display("FAIL abort_async_nsync got=%0b exp=1", nsync); end
      checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL abort_reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
      checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL abort_reset_valid got=%0b exp=0", sample_valid); end
      checks++; if (sample_index !== 16'd0) begin failures++; $display("FAIL abort_reset_index got=%0d exp=0", sample_index); end
      checks++; if (locked !== 1'b0 || pps_lost !== 1'b0 || slip !== 1'b0) begin
         failures++;
         $display("FAIL abort_reset_flags got=%0b%0b%0b exp=000", locked, pps_lost, slip);
      end
      #20;
      nrst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_slip();
      test_coincidence();
      test_pps_loss();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
